// File: rtl/dma_channel_engine.sv
// dma_channel_engine: single-channel word-copy DMA with a TileLink-UL master port.
// Copies size_i bytes from src_i to dest_i one 32-bit Get/PutFullData pair at a time,
// with at most one transaction outstanding.
// Optional build macro: DMA_CORRUPT_CHECK_EN (treat d_corrupt on an accepted D beat as an error).
module dma_channel_engine #(
    parameter int unsigned TL_AW = 32
) (
    input  logic             dma_clock_i,
    input  logic             dma_reset_i,
    input  logic             start_i,
    input  logic [TL_AW-1:0] src_i,
    input  logic [TL_AW-1:0] dest_i,
    input  logic [31:0]      size_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       a_opcode,
    output logic [2:0]       a_param,
    output logic [3:0]       a_size,
    output logic [TL_AW-1:0] a_address,
    output logic [3:0]       a_mask,
    output logic [31:0]      a_data,
    output logic             a_corrupt,
    output logic             a_valid,
    input  logic             a_ready,
    input  logic [2:0]       d_opcode,
    input  logic [1:0]       d_param,
    input  logic [3:0]       d_size,
    input  logic             d_denied,
    input  logic [31:0]      d_data,
    input  logic             d_corrupt,
    input  logic             d_valid,
    output logic             d_ready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_ACK       = 3'd0;
    localparam logic [2:0] OP_ACK_DATA  = 3'd1;

    logic [2:0]        r_state;
    logic [TL_AW-1:0]  r_src;
    logic [TL_AW-1:0]  r_dest;
    logic [SIZE_W-1:0] r_rem;
    logic [DATA_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_a_valid;
    logic              r_d_ready;
    logic [2:0]        r_a_opcode;
    logic [TL_AW-1:0]  r_a_address;
    logic [DATA_W-1:0] r_a_data;

    logic [2:0]        w_state_nxt;
    logic [TL_AW-1:0]  w_src_nxt;
    logic [TL_AW-1:0]  w_dest_nxt;
    logic [SIZE_W-1:0] w_rem_nxt;
    logic [SIZE_W-1:0] w_rem_dec;
    logic [DATA_W-1:0] w_hold_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_a_fire;
    logic              w_d_fire;
    logic              w_d_bad;
    logic              w_misaligned;
    logic              w_unused_d;

    assign w_a_fire     = r_a_valid & a_ready;
    assign w_d_fire     = d_valid & r_d_ready;
    assign w_misaligned = |{src_i[1:0], dest_i[1:0], size_i[1:0]};

`ifdef DMA_CORRUPT_CHECK_EN
    assign w_d_bad    = d_denied | d_corrupt;
    assign w_unused_d = ^{d_param, d_size};
`else
    assign w_d_bad    = d_denied;
    assign w_unused_d = ^{d_param, d_size, d_corrupt};
`endif

    // Next-state and datapath update for the copy sequence
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dest_nxt  = r_dest;
        w_rem_nxt   = r_rem;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_rem_dec   = r_rem - SIZE_W'(4);
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_src_nxt  = src_i;
                    w_dest_nxt = dest_i;
                    w_rem_nxt  = size_i;
                    w_done_nxt = 1'b0;
                    w_err_nxt  = 1'b0;
                    if (w_misaligned) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else if (size_i == SIZE_W'(0)) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (w_a_fire) w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_d_fire) begin
                    if (w_d_bad || (d_opcode != OP_ACK_DATA)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_hold_nxt  = d_data;
                        w_state_nxt = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (w_a_fire) w_state_nxt = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (w_d_fire) begin
                    if (w_d_bad || (d_opcode != OP_ACK)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_src_nxt   = r_src + TL_AW'(4);
                        w_dest_nxt  = r_dest + TL_AW'(4);
                        w_rem_nxt   = w_rem_dec;
                        w_state_nxt = (w_rem_dec != SIZE_W'(0)) ? ST_RD_REQ : ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state and registered status/handshake outputs
    always_ff @(posedge dma_clock_i) begin
        if (dma_reset_i) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_a_valid  <= 1'b0;
            r_d_ready  <= 1'b1;
            r_a_opcode <= OP_GET;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_a_valid  <= (w_state_nxt == ST_RD_REQ) || (w_state_nxt == ST_WR_REQ);
            r_d_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RD_WAIT) ||
                          (w_state_nxt == ST_WR_WAIT);
            r_a_opcode <= (w_state_nxt == ST_WR_REQ) ? OP_PUT_FULL : OP_GET;
        end
    end

    // Datapath registers; A-channel payload follows the state being entered
    always_ff @(posedge dma_clock_i) begin
        r_src       <= w_src_nxt;
        r_dest      <= w_dest_nxt;
        r_rem       <= w_rem_nxt;
        r_hold      <= w_hold_nxt;
        r_a_address <= (w_state_nxt == ST_WR_REQ) ? w_dest_nxt : w_src_nxt;
        r_a_data    <= w_hold_nxt;
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign a_valid   = r_a_valid;
    assign a_opcode  = r_a_opcode;
    assign a_address = r_a_address;
    assign a_data    = r_a_data;
    assign a_param   = 3'd0;
    assign a_size    = 4'd2;
    assign a_mask    = 4'hF;
    assign a_corrupt = 1'b0;
    assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_dma_channel_engine.sv
// Self-checking bench for dma_channel_engine: TileLink-UL slave model, transaction
// log, and a word-list reference model of the copy.
module tb_dma_channel_engine;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] src_i, dest_i;
    logic [31:0]   size_i;
    logic          busy_o, done_o, err_o;
    logic [2:0]    a_opcode, a_param;
    logic [3:0]    a_size, a_mask;
    logic [AW-1:0] a_address;
    logic [31:0]   a_data;
    logic          a_corrupt, a_valid, a_ready;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [3:0]    d_size;
    logic          d_denied, d_corrupt, d_valid, d_ready;
    logic [31:0]   d_data;

    always #5 clk = ~clk;

    dma_channel_engine #(.TL_AW(AW)) dut (
        .dma_clock_i(clk), .dma_reset_i(rst), .start_i(start_i),
        .src_i(src_i), .dest_i(dest_i), .size_i(size_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_address(a_address),
        .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt), .a_valid(a_valid),
        .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid), .d_ready(d_ready)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        string       name;
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] size;
        int          fidx;
        int          fkind;
        int          stall;
        int          ghost;
        bit          exp_err;
        int          exp_ntx;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    txn_t log_q[$];
    txn_t exp_q[$];
    bit   exp_err;

    // slave configuration
    int   stall_cnt = 0;
    bit   rand_stall = 0;
    bit   rand_delay = 0;
    int   resp_delay = 0;
    int   fault_idx = -1;
    int   fault_kind = 0;
    bit   corrupt_all = 0;
    int   get_cnt = 0;
    // slave bookkeeping
    bit   a_fire_prev = 0, d_fire_prev = 0, stalled_prev = 0;
    int   pend_cnt = -1;
    logic [2:0]  pend_op;
    logic [31:0] pend_addr;
    bit   pend_fault;
    logic [2:0]  sv_op;
    logic [31:0] sv_addr, sv_data;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the transfer is a list of words; each word is Get(src+4k) then
    // Put(dest+4k, mem[src+4k]); a faulty read response ends the list with an error.
    task automatic model(input logic [31:0] s, d, z, input int fidx, input bit corr);
        txn_t t;
        exp_q.delete();
        exp_err = 0;
        if ((s[1:0] != 0) || (d[1:0] != 0) || (z[1:0] != 0)) begin
            exp_err = 1;
            return;
        end
        for (int k = 0; k < int'(z / 4); k++) begin
            t.op = 3'd4; t.addr = s + 32'(4 * k); t.data = 'x;
            exp_q.push_back(t);
            if (k == fidx) begin exp_err = 1; return; end
`ifdef DMA_CORRUPT_CHECK_EN
            if (corr) begin exp_err = 1; return; end
`endif
            t.op = 3'd0; t.addr = d + 32'(4 * k); t.data = memval(s + 32'(4 * k));
            exp_q.push_back(t);
        end
    endtask

    // TileLink-UL slave: drives a_ready/D channel, logs A fires, checks A stability
    initial begin
        a_ready = 0; d_valid = 0; d_opcode = 0; d_param = 0; d_size = 4'd2;
        d_denied = 0; d_data = 0; d_corrupt = 0;
        forever begin
            @(posedge clk); #1;
            if (d_fire_prev) d_valid = 0;
            if (a_fire_prev) pend_cnt = rand_delay ? int'($urandom_range(0, 2)) : resp_delay;
            if (pend_cnt == 0) begin
                d_valid   = 1;
                d_corrupt = corrupt_all;
                if (pend_op == 3'd4) begin
                    d_opcode = (pend_fault && fault_kind == 1) ? 3'd0 : 3'd1;
                    d_denied = pend_fault && fault_kind == 0;
                    d_data   = memval(pend_addr);
                end else begin
                    d_opcode = 3'd0; d_denied = 0; d_data = 32'hDEAD_BEEF;
                end
                pend_cnt = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            if (stall_cnt > 0) begin
                a_ready = 0; stall_cnt--;
            end else begin
                a_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (stalled_prev && a_valid)
                chk("a_stable", {a_opcode, a_address, a_data}, {sv_op, sv_addr, sv_data});
            stalled_prev = a_valid & ~a_ready;
            sv_op = a_opcode; sv_addr = a_address; sv_data = a_data;
            a_fire_prev = a_valid & a_ready;
            if (a_fire_prev) begin
                txn_t t;
                t.op = a_opcode; t.addr = a_address; t.data = (a_opcode == 3'd0) ? a_data : 'x;
                log_q.push_back(t);
                pend_op = a_opcode; pend_addr = a_address;
                pend_fault = (a_opcode == 3'd4) && (get_cnt == fault_idx);
                if (a_opcode == 3'd4) get_cnt++;
                if (a_param != 0 || a_size != 4'd2 || a_mask != 4'hF || a_corrupt != 0)
                    chk("a_fixed_fields", {a_param, a_size, a_mask, a_corrupt}, {3'd0, 4'd2, 4'hF, 1'b0});
            end
            d_fire_prev = d_valid & d_ready;
        end
    end

    // One transfer: start, wait for idle, compare status and bus log with the model
    task automatic run_xfer(input string name, input logic [31:0] s, d, z, input int fidx,
                            input int fkind, input bit corr, input int stall, input int ghost,
                            output bit act_err, output int act_ntx);
        int n;
        int busy_cycles;
        model(s, d, z, fidx, corr);
        log_q.delete();
        get_cnt = 0; fault_idx = fidx; fault_kind = fkind; corrupt_all = corr; stall_cnt = stall;
        start_i = 1; src_i = s; dest_i = d; size_i = z;
        @(posedge clk); #2;
        start_i = 0;
        chk({name, "/done_clr"}, done_o, 0);
        chk({name, "/busy_at_start"}, busy_o, 1);
        chk({name, "/a_valid_next"}, a_valid, (exp_q.size() > 0));
        busy_cycles = 0;
        for (n = 0; n < 3000 && busy_o; n++) begin
            busy_cycles++;
            @(posedge clk); #2;
            if (n == ghost) begin
                start_i = 1; src_i = 32'h7777_0000; dest_i = 32'h8888_0000; size_i = 32'd64;
            end else begin
                start_i = 0;
            end
        end
        start_i = 0;
        if (busy_o) begin
            failures++; checks++;
            $display("FAIL %s/timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
        if (exp_q.size() == 0) chk({name, "/busy_cycles"}, busy_cycles, 1);
        chk({name, "/done"}, done_o, 1);
        chk({name, "/err"}, err_o, exp_err);
        chk({name, "/ntx"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].op !== exp_q[i].op || log_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].op == 3'd0 && log_q[i].data !== exp_q[i].data)) begin
                failures++;
                $display("FAIL %s/txn%0d: got op=%0d addr=0x%0h data=0x%0h expected op=%0d addr=0x%0h data=0x%0h",
                         name, i, log_q[i].op, log_q[i].addr, log_q[i].data,
                         exp_q[i].op, exp_q[i].addr, exp_q[i].data);
            end
        end
        act_err = err_o;
        act_ntx = log_q.size();
        repeat (2) begin
            @(posedge clk); #2;
            chk({name, "/stay_idle"}, {busy_o, a_valid}, 2'b00);
        end
    endtask

    initial begin
        vec_t vecs[10];
        bit   e;
        int   nt;
        int   n;
        vecs[0] = '{"basic8",   32'h1000, 32'h2000, 32'd8,  -1, 0, 0, -1, 0, 4};
        vecs[1] = '{"size0",    32'h1000, 32'h2000, 32'd0,  -1, 0, 0, -1, 0, 0};
        vecs[2] = '{"src_mis",  32'h1002, 32'h2000, 32'd8,  -1, 0, 0, -1, 1, 0};
        vecs[3] = '{"dst_mis",  32'h1000, 32'h2001, 32'd8,  -1, 0, 0, -1, 1, 0};
        vecs[4] = '{"size_mis", 32'h1000, 32'h2000, 32'd6,  -1, 0, 0, -1, 1, 0};
        vecs[5] = '{"deny_g2",  32'h1100, 32'h2100, 32'd12,  1, 0, 0, -1, 1, 3};
        vecs[6] = '{"bad_op",   32'h1200, 32'h2200, 32'd8,   0, 1, 0, -1, 1, 1};
        vecs[7] = '{"wrap",     32'hFFFF_FFFC, 32'h10, 32'd8, -1, 0, 0, -1, 0, 4};
        vecs[8] = '{"stall_gh", 32'h5000, 32'h6000, 32'd16, -1, 0, 5, 2, 0, 8};
        vecs[9] = '{"single",   32'h3000, 32'h4000, 32'd4,  -1, 0, 0, -1, 0, 2};

        rst = 1; start_i = 0; src_i = 0; dest_i = 0; size_i = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", {busy_o, done_o, err_o, a_valid, d_ready}, 5'b00001);
        rst = 0;
        @(posedge clk); #2;

        for (int i = 0; i < 10; i++) begin
            run_xfer(vecs[i].name, vecs[i].src, vecs[i].dest, vecs[i].size, vecs[i].fidx,
                     vecs[i].fkind, 1'b0, vecs[i].stall, vecs[i].ghost, e, nt);
            chk({vecs[i].name, "/tbl_err"}, e, vecs[i].exp_err);
            chk({vecs[i].name, "/tbl_ntx"}, nt, vecs[i].exp_ntx);
        end

        // randomized transfers with random stalls, latency, faults and corrupt flags
        rand_stall = 1; rand_delay = 1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] s, d, z;
            int fidx;
            s = $urandom & ~32'd3; d = $urandom & ~32'd3;
            z = 32'(4 * $urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) s[0] = 1'b1;
            fidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(z / 4) - 1)) : -1;
            run_xfer($sformatf("rand%0d", i), s, d, z, fidx, int'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) == 0), 0, -1, e, nt);
        end
        rand_stall = 0; rand_delay = 0; corrupt_all = 0; fault_idx = -1;

        // reset while waiting for the write ack; late ack must be drained in IDLE
        resp_delay = 4;
        log_q.delete(); get_cnt = 0;
        start_i = 1; src_i = 32'h3000; dest_i = 32'h4000; size_i = 32'd4;
        @(posedge clk); #2;
        start_i = 0;
        for (n = 0; n < 50 && log_q.size() < 2; n++) begin
            @(posedge clk); #2;
        end
        chk("rst_mid/put_seen", log_q.size(), 2);
        @(posedge clk); #2;
        chk("rst_mid/in_wr_wait", {busy_o, a_valid, d_ready}, 3'b101);
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        chk("rst_mid/after_reset", {busy_o, a_valid, done_o, err_o, d_ready}, 5'b00001);
        for (n = 0; n < 20 && !d_fire_prev; n++) begin
            @(posedge clk); #2;
            chk("rst_mid/idle_wait", {busy_o, a_valid}, 2'b00);
        end
        chk("rst_mid/ack_drained", d_fire_prev, 1);
        repeat (3) begin
            @(posedge clk); #2;
            chk("rst_mid/post_drain", {busy_o, a_valid, done_o, err_o}, 4'b0000);
        end
        resp_delay = 0;
        run_xfer("recover", 32'h8000, 32'h9000, 32'd8, -1, 0, 1'b0, 0, -1, e, nt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
